// File: rtl/kubo_uart_rx_pkg.sv
// Shared UART definitions: FSM state type and default bit timing.
// Also intended for the planned transmitter.
package kubo_uart_rx_pkg;

    localparam int unsigned DEFAULT_CLKS_PER_BIT = 434;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BRK
    } state_t;

endpackage

// File: rtl/kubo_sync2.sv
// Generic two-flop synchroniser with a configurable reset value.
module kubo_sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_d,
    output logic o_q
);

    logic [1:0] ff;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            ff <= {2{RESET_VAL}};
        end else begin
            ff <= {ff[0], i_d};
        end
    end

    assign o_q = ff[1];

endmodule

// File: rtl/kubo_uart_rx.sv
// 8N1 UART receiver: mid-bit sampling, one-cycle strobes for good bytes and
// for frames whose stop bit samples low.
module kubo_uart_rx
    import kubo_uart_rx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_en,
    input  logic       i_rx,
    output logic [7:0] o_data,
    output logic       o_data_valid,
    output logic       o_frame_err,
    output logic       o_busy
);

    localparam int unsigned HALF_BIT = CLKS_PER_BIT / 2;
    localparam int unsigned BAUD_W   = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BAUD_W-1:0] HALF_LAST = BAUD_W'(HALF_BIT - 1);

    state_t            state;
    logic [BAUD_W-1:0] baud;
    logic [2:0]        bit_cnt;
    logic [7:0]        shift;
    logic              rx_s;

    kubo_sync2 #(.RESET_VAL(1'b1)) u_sync (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_d     (i_rx),
        .o_q     (rx_s)
    );

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state        <= ST_IDLE;
            baud         <= '0;
            bit_cnt      <= '0;
            shift        <= '0;
            o_data       <= '0;
            o_data_valid <= 1'b0;
            o_frame_err  <= 1'b0;
        end else begin
            o_data_valid <= 1'b0;
            o_frame_err  <= 1'b0;
            if (!i_en) begin
                state   <= ST_IDLE;
                baud    <= '0;
                bit_cnt <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (!rx_s) begin
                            state   <= ST_START;
                            baud    <= '0;
                            bit_cnt <= '0;
                        end
                    end
                    ST_START: begin
                        if (baud == HALF_LAST) begin
                            baud  <= '0;
                            state <= rx_s ? ST_IDLE : ST_DATA;
                        end else begin
                            baud <= baud + BAUD_W'(1);
                        end
                    end
                    ST_DATA: begin
                        if (baud == BAUD_LAST) begin
                            baud    <= '0;
                            shift   <= {rx_s, shift[7:1]};
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                state <= ST_STOP;
                            end
                        end else begin
                            baud <= baud + BAUD_W'(1);
                        end
                    end
                    ST_STOP: begin
                        if (baud == BAUD_LAST) begin
                            baud <= '0;
                            if (rx_s) begin
                                o_data       <= shift;
                                o_data_valid <= 1'b1;
                                state        <= ST_IDLE;
                            end else begin
                                o_frame_err <= 1'b1;
                                state       <= ST_BRK;
                            end
                        end else begin
                            baud <= baud + BAUD_W'(1);
                        end
                    end
                    ST_BRK: begin
                        // Line held low after a bad stop bit: wait for idle.
                        if (rx_s) begin
                            state <= ST_IDLE;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    assign o_busy = (state != ST_IDLE);

endmodule
